// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings, select codes and enums for the MIPS
//               multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;

    localparam logic [1:0] c_RD_RT    = 2'b00;
    localparam logic [1:0] c_RD_RD    = 2'b01;
    localparam logic [1:0] c_RD_RA    = 2'b10;

    localparam logic [1:0] c_WR_ALU   = 2'b00;
    localparam logic [1:0] c_WR_SLT   = 2'b01;
    localparam logic [1:0] c_WR_MEM   = 2'b10;
    localparam logic [1:0] c_WR_PC4   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE    = 4'd0,
        CLS_ADD     = 4'd1,
        CLS_SUB     = 4'd2,
        CLS_SLT     = 4'd3,
        CLS_JR      = 4'd4,
        CLS_ADDI    = 4'd5,
        CLS_SLTI    = 4'd6,
        CLS_LW      = 4'd7,
        CLS_SW      = 4'd8,
        CLS_BEQ     = 4'd9,
        CLS_J       = 4'd10,
        CLS_JAL     = 4'd11,
        CLS_ILLEGAL = 4'd12
    } cls_t;

endpackage
`default_nettype wire

// File: rtl/mips_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl_if
// Description : Control/status bundle between the controller and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       op;
    logic [5:0]       func;
    logic             zero;
    logic             pc_en;
    logic             J_type;
    logic             Branch;
    logic             PCsrc;
    logic             RegWrite;
    logic             ALUsrc;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       ALUop;
    logic [1:0]       RegDest;
    logic [1:0]       WriteReg;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, op, func, zero,
        output pc_en, J_type, Branch, PCsrc, RegWrite, ALUsrc, MemRead, MemWrite,
               ALUop, RegDest, WriteReg, illegal, retired
    );

    modport slave (
        output run, op, func, zero,
        input  pc_en, J_type, Branch, PCsrc, RegWrite, ALUsrc, MemRead, MemWrite,
               ALUop, RegDest, WriteReg, illegal, retired
    );
endinterface
`default_nettype wire

// File: rtl/mips_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_decoder
// Description : Combinational op/func classifier and class-to-static-field map.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_decoder
    import mips_pkg::*;
(
    input  wire logic [5:0] i_op,
    input  wire logic [5:0] i_func,
    input  wire cls_t       i_cls,
    output cls_t            o_cls,
    output logic [2:0]      o_aluop,
    output logic            o_alusrc,
    output logic [1:0]      o_regdest,
    output logic [1:0]      o_writereg,
    output logic            o_jtype,
    output logic            o_branch
);

    always_comb begin
        o_cls = CLS_ILLEGAL;
        case (i_op)
            c_OP_RTYPE: begin
                case (i_func)
                    c_FN_ADD: o_cls = CLS_ADD;
                    c_FN_SUB: o_cls = CLS_SUB;
                    c_FN_SLT: o_cls = CLS_SLT;
                    c_FN_JR:  o_cls = CLS_JR;
                    default:  o_cls = CLS_ILLEGAL;
                endcase
            end
            c_OP_ADDI: o_cls = CLS_ADDI;
            c_OP_SLTI: o_cls = CLS_SLTI;
            c_OP_LW:   o_cls = CLS_LW;
            c_OP_SW:   o_cls = CLS_SW;
            c_OP_BEQ:  o_cls = CLS_BEQ;
            c_OP_J:    o_cls = CLS_J;
            c_OP_JAL:  o_cls = CLS_JAL;
            default:   o_cls = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        o_aluop    = c_ALU_ADD;
        o_alusrc   = 1'b0;
        o_regdest  = c_RD_RT;
        o_writereg = c_WR_ALU;
        o_jtype    = 1'b0;
        o_branch   = 1'b0;
        case (i_cls)
            CLS_ADD:  o_regdest = c_RD_RD;
            CLS_SUB: begin
                o_aluop   = c_ALU_SUB;
                o_regdest = c_RD_RD;
            end
            CLS_SLT: begin
                o_aluop    = c_ALU_SUB;
                o_regdest  = c_RD_RD;
                o_writereg = c_WR_SLT;
            end
            CLS_ADDI: o_alusrc = 1'b1;
            CLS_SLTI: begin
                o_alusrc   = 1'b1;
                o_aluop    = c_ALU_SUB;
                o_writereg = c_WR_SLT;
            end
            CLS_LW: begin
                o_alusrc   = 1'b1;
                o_writereg = c_WR_MEM;
            end
            CLS_SW:   o_alusrc = 1'b1;
            CLS_BEQ: begin
                o_aluop  = c_ALU_SUB;
                o_branch = 1'b1;
            end
            CLS_JR:   o_jtype = 1'b1;
            CLS_JAL: begin
                o_regdest  = c_RD_RA;
                o_writereg = c_WR_PC4;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Multi-cycle MIPS controller: state sequencing, strobes,
//               retired-instruction counter and illegal-encoding trap.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  wire logic      clk,
    input  wire logic      rst,
    mips_mc_ctrl_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    cls_t             r_cls;
    cls_t             w_dec_cls;
    logic [CNT_W-1:0] r_retired;

    logic [2:0] w_aluop;
    logic       w_alusrc;
    logic [1:0] w_regdest;
    logic [1:0] w_writereg;
    logic       w_jtype;
    logic       w_branch;
    logic       w_static_en;

    logic w_pc_en;
    logic w_pcsrc;
    logic w_regwrite;
    logic w_memread;
    logic w_memwrite;

    mips_decoder u_decoder (
        .i_op       (bus.op),
        .i_func     (bus.func),
        .i_cls      (r_cls),
        .o_cls      (w_dec_cls),
        .o_aluop    (w_aluop),
        .o_alusrc   (w_alusrc),
        .o_regdest  (w_regdest),
        .o_writereg (w_writereg),
        .o_jtype    (w_jtype),
        .o_branch   (w_branch)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_cls     <= CLS_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_cls <= w_dec_cls;
            if (w_pc_en)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pc_en    = 1'b0;
        w_pcsrc    = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        case (r_state)
            S_FETCH:  if (bus.run) w_next = S_DECODE;
            S_DECODE: w_next = (w_dec_cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (r_cls)
                    // Only combinational path to an output: branch resolves in EXEC.
                    CLS_BEQ: begin
                        w_pcsrc = bus.zero;
                        w_pc_en = 1'b1;
                        w_next  = S_FETCH;
                    end
                    CLS_J, CLS_JR: begin
                        w_pcsrc = 1'b1;
                        w_pc_en = 1'b1;
                        w_next  = S_FETCH;
                    end
                    CLS_JAL: begin
                        w_pcsrc    = 1'b1;
                        w_regwrite = 1'b1;
                        w_pc_en    = 1'b1;
                        w_next     = S_FETCH;
                    end
                    CLS_LW, CLS_SW:                                 w_next = S_MEM;
                    CLS_ADD, CLS_SUB, CLS_SLT, CLS_ADDI, CLS_SLTI: w_next = S_WB;
                    default:                                        w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (r_cls == CLS_LW) begin
                    w_memread = 1'b1;
                    w_next    = S_WB;
                end else begin
                    w_memwrite = 1'b1;
                    w_pc_en    = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_pc_en    = 1'b1;
                w_memread  = (r_cls == CLS_LW);
                w_next     = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    assign w_static_en = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

    assign bus.pc_en    = w_pc_en;
    assign bus.PCsrc    = w_pcsrc;
    assign bus.RegWrite = w_regwrite;
    assign bus.MemRead  = w_memread;
    assign bus.MemWrite = w_memwrite;
    assign bus.ALUop    = w_static_en ? w_aluop    : 3'b000;
    assign bus.ALUsrc   = w_static_en & w_alusrc;
    assign bus.RegDest  = w_static_en ? w_regdest  : 2'b00;
    assign bus.WriteReg = w_static_en ? w_writereg : 2'b00;
    assign bus.J_type   = w_static_en & w_jtype;
    assign bus.Branch   = w_static_en & w_branch;
    assign bus.illegal  = (r_state == S_TRAP);
    assign bus.retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mc_ctrl
// Description : Directed self-checking bench for the multi-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [CNT_W-1:0] exp_ret;
    logic [15:0] obs;

    mips_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_mc_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.pc_en, bus.J_type, bus.Branch, bus.PCsrc, bus.RegWrite,
                  bus.ALUsrc, bus.MemRead, bus.MemWrite, bus.ALUop,
                  bus.RegDest, bus.WriteReg, bus.illegal};

    function automatic logic [15:0] mk(input logic pc, jt, br, pcs, rw, als, mr, mw,
                                       input logic [2:0] alu, input logic [1:0] rd, wr,
                                       input logic ill);
        return {pc, jt, br, pcs, rw, als, mr, mw, alu, rd, wr, ill};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_ret(input string tag);
        n_assert++;
        assert (bus.retired === exp_ret) else begin
            n_fail++;
            $error("FAIL %s retired observed=%0d expected=%0d", tag, bus.retired, exp_ret);
        end
    endtask

    // Called at a negedge while in FETCH; returns at the negedge of the next FETCH.
    task automatic instr(input string tag, input logic [5:0] op, fn, input logic z,
                         input int n, input logic [15:0] e_ex, e_4, e_5);
        bus.run = 1'b1; bus.op = op; bus.func = fn; bus.zero = z;
        chk({tag, ":fetch"}, 16'h0);
        @(negedge clk); chk({tag, ":decode"}, 16'h0);
        @(negedge clk); chk({tag, ":exec"}, e_ex);
        if (n >= 4) begin @(negedge clk); chk({tag, ":st4"}, e_4); end
        if (n == 5) begin @(negedge clk); chk({tag, ":st5"}, e_5); end
        @(negedge clk);
        exp_ret = exp_ret + 1'b1;
        chk({tag, ":back_fetch"}, 16'h0);
        chk_ret({tag, ":retired"});
    endtask

    task automatic trap_run(input string tag, input logic [5:0] op, fn, input int n);
        bus.run = 1'b1; bus.op = op; bus.func = fn; bus.zero = 1'b0;
        chk({tag, ":fetch"}, 16'h0);
        @(negedge clk); chk({tag, ":decode"}, 16'h0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ":trap"}, mk(0,0,0,0,0,0,0,0,3'd0,2'd0,2'd0,1));
        end
        chk_ret({tag, ":trap_retired"});
        #2 rst = 1'b0;
        #1 chk({tag, ":async_clear"}, 16'h0);
        exp_ret = '0;
        chk_ret({tag, ":clear_retired"});
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_ret  = '0;
        rst      = 1'b0;
        bus.run  = 1'b0;
        bus.op   = 6'h0;
        bus.func = 6'h0;
        bus.zero = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset:outs", 16'h0);
        chk_ret("reset:retired");
        rst = 1'b1;

        instr("add", c_OP_RTYPE, c_FN_ADD, 0, 4,
              mk(0,0,0,0,0,0,0,0,3'd0,2'd1,2'd0,0),
              mk(1,0,0,0,1,0,0,0,3'd0,2'd1,2'd0,0), 16'h0);
        instr("lw", c_OP_LW, 6'h0, 0, 5,
              mk(0,0,0,0,0,1,0,0,3'd0,2'd0,2'd2,0),
              mk(0,0,0,0,0,1,1,0,3'd0,2'd0,2'd2,0),
              mk(1,0,0,0,1,1,1,0,3'd0,2'd0,2'd2,0));
        instr("sw", c_OP_SW, 6'h0, 0, 4,
              mk(0,0,0,0,0,1,0,0,3'd0,2'd0,2'd0,0),
              mk(1,0,0,0,0,1,0,1,3'd0,2'd0,2'd0,0), 16'h0);
        instr("beq_z1", c_OP_BEQ, 6'h0, 1, 3,
              mk(1,0,1,1,0,0,0,0,3'd1,2'd0,2'd0,0), 16'h0, 16'h0);
        instr("beq_z0", c_OP_BEQ, 6'h0, 0, 3,
              mk(1,0,1,0,0,0,0,0,3'd1,2'd0,2'd0,0), 16'h0, 16'h0);
        instr("jal", c_OP_JAL, 6'h0, 0, 3,
              mk(1,0,0,1,1,0,0,0,3'd0,2'd2,2'd3,0), 16'h0, 16'h0);
        instr("jr", c_OP_RTYPE, c_FN_JR, 0, 3,
              mk(1,1,0,1,0,0,0,0,3'd0,2'd0,2'd0,0), 16'h0, 16'h0);
        instr("j", c_OP_J, 6'h0, 0, 3,
              mk(1,0,0,1,0,0,0,0,3'd0,2'd0,2'd0,0), 16'h0, 16'h0);
        instr("sub", c_OP_RTYPE, c_FN_SUB, 0, 4,
              mk(0,0,0,0,0,0,0,0,3'd1,2'd1,2'd0,0),
              mk(1,0,0,0,1,0,0,0,3'd1,2'd1,2'd0,0), 16'h0);
        instr("slt", c_OP_RTYPE, c_FN_SLT, 0, 4,
              mk(0,0,0,0,0,0,0,0,3'd1,2'd1,2'd1,0),
              mk(1,0,0,0,1,0,0,0,3'd1,2'd1,2'd1,0), 16'h0);
        instr("addi", c_OP_ADDI, 6'h0, 0, 4,
              mk(0,0,0,0,0,1,0,0,3'd0,2'd0,2'd0,0),
              mk(1,0,0,0,1,1,0,0,3'd0,2'd0,2'd0,0), 16'h0);
        instr("slti", c_OP_SLTI, 6'h0, 0, 4,
              mk(0,0,0,0,0,1,0,0,3'd1,2'd0,2'd1,0),
              mk(1,0,0,0,1,1,0,0,3'd1,2'd0,2'd1,0), 16'h0);

        bus.run = 1'b0;
        bus.op  = c_OP_J;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("run_low:hold", 16'h0);
            chk_ret("run_low:retired");
        end

        // Four more take a 4-bit counter from 12 through 15 and back to 0.
        for (int i = 0; i < 4; i++)
            instr("wrap_j", c_OP_J, 6'h0, 0, 3,
                  mk(1,0,0,1,0,0,0,0,3'd0,2'd0,2'd0,0), 16'h0, 16'h0);

        bus.run = 1'b1; bus.op = c_OP_LW; bus.func = 6'h0;
        chk("abort:fetch", 16'h0);
        @(negedge clk); chk("abort:decode", 16'h0);
        @(negedge clk); chk("abort:exec", mk(0,0,0,0,0,1,0,0,3'd0,2'd0,2'd2,0));
        @(negedge clk); chk("abort:mem",  mk(0,0,0,0,0,1,1,0,3'd0,2'd0,2'd2,0));
        #1 rst = 1'b0;
        #1 chk("abort:cleared", 16'h0);
        exp_ret = '0;
        chk_ret("abort:retired");
        @(negedge clk) rst = 1'b1;

        instr("add2", c_OP_RTYPE, c_FN_ADD, 0, 4,
              mk(0,0,0,0,0,0,0,0,3'd0,2'd1,2'd0,0),
              mk(1,0,0,0,1,0,0,0,3'd0,2'd1,2'd0,0), 16'h0);

        trap_run("ill_op", 6'b111111, 6'h0, 20);
        trap_run("ill_fn", c_OP_RTYPE, 6'b111111, 3);

        instr("after_trap_j", c_OP_J, 6'h0, 0, 3,
              mk(1,0,0,1,0,0,0,0,3'd0,2'd0,2'd0,0), 16'h0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, decodes `op`/`func` into the datapath mux selects and write strobes, and gates PC updates through a new PC write enable. It also counts retired instructions and traps on unsupported encodings. It sits beside the datapath and drives all of its control inputs.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `run` input 1: permits leaving FETCH. Low holds the controller in FETCH.
- `op` input 6: instruction[31:26] from the datapath.
- `func` input 6: instruction[5:0] from the datapath.
- `zero` input 1: ALU zero flag.
- `pc_en` output 1: PC write enable. The PC loads the next PC at a rising edge only when this is 1.
- `J_type`, `Branch`, `PCsrc`, `RegWrite`, `ALUsrc`, `MemRead`, `MemWrite` output 1 each: datapath controls.
- `ALUop` output 3: 000 = add, 001 = sub.
- `RegDest` output 2: 00 = rt, 01 = rd, 10 = $31.
- `WriteReg` output 2: write-back source. 00 = ALU, 01 = ALU[31] (slt), 10 = memory, 11 = PC+4.
- `illegal` output 1: sticky trap flag.
- `retired` output CNT_W: count of completed instructions.

## Operation
- Supported instructions:
  - R-type (op 000000): add (func 100000), sub (100010), slt (101010), jr (001000).
  - I-type: addi (001000), slti (001010), lw (100011), sw (101011), beq (000100).
  - J-type: j (000010), jal (000011).
- Any other op, or an R-type with an unlisted func, is illegal.
- States are FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: the instruction memory captures at the rising edge that ends FETCH. Go to DECODE if `run`=1, else stay in FETCH.
- DECODE: register `op`/`func` into an internal instruction-class register.
  - Go to EXEC, or to TRAP if the encoding is illegal.
- Static fields (`ALUop`, `ALUsrc`, `RegDest`, `WriteReg`, `J_type`, `Branch`) are driven from the latched class from EXEC through the last state of the instruction. They are 0 in FETCH, DECODE and TRAP.
- Per-class static field values:
  - add: ALUop=000, RegDest=01, WriteReg=00.
  - sub: ALUop=001, RegDest=01, WriteReg=00.
  - slt: ALUop=001, RegDest=01, WriteReg=01.
  - addi: ALUsrc=1, ALUop=000, RegDest=00, WriteReg=00.
  - slti: ALUsrc=1, ALUop=001, RegDest=00, WriteReg=01.
  - lw: ALUsrc=1, ALUop=000, RegDest=00, WriteReg=10.
  - sw: ALUsrc=1, ALUop=000.
  - beq: ALUop=001, Branch=1.
  - j: J_type=0, Branch=0.
  - jr: J_type=1.
  - jal: RegDest=10, WriteReg=11.
- EXEC behaviour by class:
  - beq: `PCsrc`=`zero`, `pc_en`=1, then FETCH.
  - j and jr: `PCsrc`=1, `pc_en`=1, then FETCH.
  - jal: `PCsrc`=1, `RegWrite`=1, `pc_en`=1, then FETCH.
  - ALU-class (add/sub/slt/addi/slti): go to WB.
  - lw and sw: go to MEM.
- MEM behaviour:
  - lw: `MemRead`=1, then WB.
  - sw: `MemWrite`=1, `pc_en`=1, then FETCH.
- WB: `RegWrite`=1, `pc_en`=1, plus `MemRead`=1 for lw. Then FETCH.
- `retired` increments by 1 on every edge where `pc_en`=1. It wraps from all-ones to 0.
- TRAP: all strobes are 0 and `illegal`=1. The controller stays in TRAP until reset.

## Timing
- Reset (`rst`=0): state goes to FETCH immediately; all outputs are 0 and `retired`=0.
  - Asserting reset mid-instruction aborts the instruction with no register, memory or PC write.
- Instruction latency in cycles (FETCH through last state):
  - j, jr, jal, beq: 3.
  - add, sub, slt, addi, slti, sw: 4.
  - lw: 5.
- Strobes `RegWrite`, `MemWrite`, `pc_en` and `PCsrc` are asserted for exactly one cycle per instruction. Their effect lands at the rising edge that ends that cycle.
- All outputs are registered-state Moore functions, except `PCsrc` in beq EXEC. That output is combinational from `zero`.
- `run` is sampled only in FETCH. Dropping `run` mid-instruction does not stall it.

## Structure
- Package `mips_pkg` holds:
  - opcode and func constants;
  - ALUop codes;
  - RegDest and WriteReg select codes;
  - the state enum;
  - the instruction-class enum.
- Sub-module `mips_decoder`: a combinational op/func-to-class and static-field decoder. The FSM, latched class register and counter stay in `mips_mc_ctrl`.

## Test plan
- Reset, then `run`=1 with add (op 000000, func 100000):
  - FETCH→DECODE→EXEC→WB;
  - WB shows RegWrite=1, RegDest=01, WriteReg=00, ALUop=000, pc_en=1;
  - `retired`=1.
- lw (100011): five-cycle sequence, with MEM showing MemRead=1 and WB showing RegWrite=1, WriteReg=10. Then sw (101011): MemWrite is high for exactly one cycle, in MEM.
- beq (000100) with `zero`=1, then with `zero`=0:
  - the EXEC cycle shows Branch=1 and pc_en=1 in both cases;
  - PCsrc=1, then 0.
- jal (000011): EXEC shows RegWrite=1, RegDest=10, WriteReg=11, PCsrc=1, pc_en=1, J_type=0. jr (000000/001000): EXEC shows J_type=1.
- Illegal op 111111:
  - DECODE→TRAP with `illegal`=1 and no strobes for 20 cycles;
  - `rst`=0 asynchronously clears the trap and returns to FETCH.
- `run`=0 holds FETCH for 10 cycles with pc_en=0. With CNT_W=4, after 16 retired instructions `retired` wraps to 0.
